// File: rtl/crc8_pkg.sv
// rtl/crc8_pkg.sv - shared CRC-8 constants, mode encodings and framer state type
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_APPEND = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/crc8_next.sv
// rtl/crc8_next.sv - combinational CRC-8 next-state for one byte, MSB first
module crc8_next
  import crc8_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  // Eight unrolled shift/xor steps collapse into the parallel XOR equations.
  always_comb begin
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc8_frame_ctrl.sv
// rtl/crc8_frame_ctrl.sv - CRC-8 frame generator/checker between byte streams
module crc8_frame_ctrl
  import crc8_pkg::*;
#(
  parameter int         LEN_W = 16,
  parameter logic [7:0] INIT  = CRC8_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       crc_value,
  output logic             crc_ok,
  output logic [LEN_W-1:0] frame_len
);

  state_t           state;
  logic [7:0]       crc_reg;
  logic [7:0]       crc_nxt;
  logic [LEN_W-1:0] count;
  logic             mode_q;
  logic             frame_mode;
  logic             out_free;
  logic             out_fire;
  logic             accept_in;

  crc8_next u_crc8_next (
    .crc_in  (crc_reg),
    .data    (s_data),
    .crc_out (crc_nxt)
  );

  assign out_free   = !m_valid || m_ready;
  assign out_fire   = m_valid && m_ready;
  assign s_ready    = !rst && ((state == ST_IDLE) || (state == ST_DATA)) && out_free;
  assign accept_in  = s_valid && s_ready;
  // Mode is only honoured on the first byte; afterwards the latched copy rules.
  assign frame_mode = (state == ST_IDLE) ? mode : mode_q;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      crc_reg    <= INIT;
      count      <= '0;
      mode_q     <= MODE_GEN;
      m_valid    <= 1'b0;
      m_data     <= 8'h00;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      crc_value  <= 8'h00;
      crc_ok     <= 1'b0;
      frame_len  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (out_fire) begin
        m_valid <= 1'b0;
      end

      case (state)
        ST_IDLE, ST_DATA: begin
          if (accept_in) begin
            mode_q  <= frame_mode;
            m_valid <= 1'b1;
            m_data  <= s_data;
            crc_reg <= crc_nxt;
            if (count != '1) begin
              count <= count + 1'b1;
            end
            if (!s_last) begin
              m_last <= 1'b0;
              state  <= ST_DATA;
            end else if (frame_mode == MODE_GEN) begin
              m_last <= 1'b0;
              state  <= ST_APPEND;
            end else begin
              m_last <= 1'b1;
              state  <= ST_DRAIN;
            end
          end
        end

        ST_APPEND: begin
          // The last payload byte may still be stalled in the output register.
          if (out_free) begin
            m_valid <= 1'b1;
            m_data  <= crc_reg;
            m_last  <= 1'b1;
            state   <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (out_fire && m_last) begin
            frame_done <= 1'b1;
            crc_value  <= crc_reg;
            crc_ok     <= (mode_q == MODE_CHK) ? (crc_reg == 8'h00) : 1'b1;
            frame_len  <= count;
            crc_reg    <= INIT;
            count      <= '0;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// tb/tb_crc8_frame_ctrl.sv - self-checking bench for crc8_frame_ctrl
module tb_crc8_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;
  logic        frame_done;
  logic [7:0]  crc_value;
  logic        crc_ok;
  logic [15:0] frame_len;

  crc8_frame_ctrl #(.LEN_W(16), .INIT(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done),
    .crc_value  (crc_value),
    .crc_ok     (crc_ok),
    .frame_len  (frame_len)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  crc_tab [256];
  logic [7:0]  in_q[$];
  logic        in_last_q[$];
  logic        in_mode_q[$];
  logic [8:0]  out_q[$];
  logic [8:0]  exp_out_q[$];
  logic [7:0]  done_crc[$];
  logic        done_ok[$];
  logic [15:0] done_len[$];
  logic [7:0]  exp_crc[$];
  logic        exp_ok[$];
  logic [15:0] exp_len[$];
  logic [7:0]  fb[$];

  int   rdy_mode = 0;
  bit   gap_mode = 1'b0;
  bit   in_hs = 1'b0;
  int   stall_err = 0;
  int   sready_err = 0;
  int   pulse_err = 0;
  int   acc_cnt = 0;
  bit   after_last = 1'b0;
  bit   prev_stall = 1'b0;
  bit   prev_done = 1'b0;
  logic [8:0] prev_out = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: table of (i * x^8) mod (x^8+x^2+x+1) by polynomial long division.
  function automatic logic [7:0] model_crc(input logic [7:0] b[$]);
    logic [7:0] c;
    c = 8'hFF;
    foreach (b[i]) c = crc_tab[c ^ b[i]];
    return c;
  endfunction

  task automatic send_frame(input logic m);
    logic [7:0] c;
    int n;
    n = fb.size();
    c = model_crc(fb);
    for (int i = 0; i < n; i++) begin
      in_q.push_back(fb[i]);
      in_last_q.push_back(i == n - 1);
      in_mode_q.push_back((i == 0) ? m : 1'($urandom));
      exp_out_q.push_back({(m == 1'b1) && (i == n - 1), fb[i]});
    end
    if (m == 1'b0) exp_out_q.push_back({1'b1, c});
    exp_crc.push_back(c);
    exp_ok.push_back((m == 1'b1) ? (c == 8'h00) : 1'b1);
    exp_len.push_back(16'(n));
  endtask

  task automatic wait_and_check(input string tag);
    int n;
    int no;
    n = exp_crc.size();
    for (int cyc = 0; cyc < 4000 && done_crc.size() < n; cyc++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk({tag, "_frames"}, done_crc.size(), n);
    chk({tag, "_out_count"}, out_q.size(), exp_out_q.size());
    no = (out_q.size() < exp_out_q.size()) ? out_q.size() : exp_out_q.size();
    for (int i = 0; i < no; i++) chk({tag, "_out_byte"}, out_q[i], exp_out_q[i]);
    for (int i = 0; i < n && i < done_crc.size(); i++) begin
      chk({tag, "_crc_value"}, done_crc[i], exp_crc[i]);
      chk({tag, "_crc_ok"}, done_ok[i], exp_ok[i]);
      chk({tag, "_frame_len"}, done_len[i], exp_len[i]);
    end
    chk({tag, "_stall_stable"}, stall_err, 0);
    chk({tag, "_sready_after_last"}, sready_err, 0);
    chk({tag, "_done_pulse"}, pulse_err, 0);
    stall_err = 0; sready_err = 0; pulse_err = 0;
    out_q.delete(); exp_out_q.delete();
    done_crc.delete(); done_ok.delete(); done_len.delete();
    exp_crc.delete(); exp_ok.delete(); exp_len.delete();
  endtask

  // Input driver and sink readiness, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (in_hs && in_q.size() > 0) begin
        void'(in_q.pop_front());
        void'(in_last_q.pop_front());
        void'(in_mode_q.pop_front());
      end
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (in_q.size() > 0 && !(gap_mode && $urandom_range(0, 3) == 0)) begin
        s_valid = 1'b1;
        s_data  = in_q[0];
        s_last  = in_last_q[0];
        mode    = in_mode_q[0];
      end else begin
        s_valid = 1'b0;
        mode    = 1'($urandom);
      end
    end
  end

  // Monitor: records handshakes and result pulses, tracks protocol rules.
  initial begin
    forever begin
      @(negedge clk);
      in_hs = s_valid && s_ready;
      if (!rst) begin
        if (prev_stall && (({m_last, m_data} !== prev_out) || (m_valid !== 1'b1))) stall_err++;
        prev_stall = m_valid && !m_ready;
        prev_out   = {m_last, m_data};
        if (m_valid && m_ready) out_q.push_back({m_last, m_data});
        if (frame_done) begin
          if (prev_done) pulse_err++;
          done_crc.push_back(crc_value);
          done_ok.push_back(crc_ok);
          done_len.push_back(frame_len);
          after_last = 1'b0;
        end
        prev_done = frame_done;
        if (after_last && s_ready) sready_err++;
        if (in_hs) acc_cnt++;
        if (in_hs && s_last) after_last = 1'b1;
      end else begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        after_last = 1'b0;
      end
    end
  end

  initial begin
    logic [15:0] v;
    logic        rm;
    int          rlen;
    logic [7:0]  rc;
    int          acc0;

    for (int i = 0; i < 256; i++) begin
      v = 16'(i) << 8;
      for (int b = 15; b >= 8; b--) begin
        if (v[b]) v = v ^ (16'h0107 << (b - 8));
      end
      crc_tab[i] = v[7:0];
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_crc_value", crc_value, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_frame_len", frame_len, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 1);
    chk("idle_busy", busy, 0);

    rdy_mode = 0;
    fb.delete(); fb.push_back(8'h00);
    send_frame(1'b0);
    wait_and_check("gen_single");
    chk("gen_single_crc_const", crc_value, 8'hF3);
    chk("gen_single_len_const", frame_len, 1);
    chk("gen_single_ok_const", crc_ok, 1);

    fb.delete(); fb.push_back(8'h00); fb.push_back(8'h00);
    send_frame(1'b0);
    wait_and_check("gen_two");
    chk("gen_two_crc_const", crc_value, 8'hD7);
    chk("gen_two_len_const", frame_len, 2);

    fb.delete(); fb.push_back(8'h01);
    send_frame(1'b0);
    wait_and_check("gen_01");
    chk("gen_01_crc_const", crc_value, 8'hF4);

    fb.delete(); fb.push_back(8'h00); fb.push_back(8'hF3);
    send_frame(1'b1);
    wait_and_check("chk_good");
    chk("chk_good_ok_const", crc_ok, 1);
    chk("chk_good_crc_const", crc_value, 8'h00);
    chk("chk_good_len_const", frame_len, 2);

    fb.delete(); fb.push_back(8'h00); fb.push_back(8'hF2);
    send_frame(1'b1);
    wait_and_check("chk_bad");
    chk("chk_bad_ok_const", crc_ok, 0);
    chk("chk_bad_residue_nonzero", (crc_value != 8'h00), 1);

    fb.delete(); fb.push_back(8'hFF);
    send_frame(1'b1);
    wait_and_check("chk_single");
    chk("chk_single_ok_const", crc_ok, 1);

    rdy_mode = 1;
    fb.delete(); fb.push_back(8'h00); fb.push_back(8'h00);
    send_frame(1'b0);
    wait_and_check("gen_backpressure");
    chk("gen_bp_crc_const", crc_value, 8'hD7);

    rdy_mode = 0;
    fb.delete(); fb.push_back(8'h01);
    send_frame(1'b0);
    fb.delete(); fb.push_back(8'h00); fb.push_back(8'hF3);
    send_frame(1'b1);
    wait_and_check("back_to_back");
    chk("b2b_ok_const", crc_ok, 1);
    chk("b2b_crc_const", crc_value, 8'h00);

    // Abort a GEN frame after its first byte has been taken.
    acc0 = acc_cnt;
    in_q.push_back(8'h00); in_last_q.push_back(1'b0); in_mode_q.push_back(1'b0);
    in_q.push_back(8'h11); in_last_q.push_back(1'b1); in_mode_q.push_back(1'b0);
    for (int cyc = 0; cyc < 50 && acc_cnt == acc0; cyc++) @(negedge clk);
    chk("abort_first_accept", acc_cnt, acc0 + 1);
    @(posedge clk);
    #2 rst = 1'b1;
    in_q.delete(); in_last_q.delete(); in_mode_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_done", frame_done, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_crc.size(), 0);
    out_q.delete();
    fb.delete(); fb.push_back(8'h00);
    send_frame(1'b0);
    wait_and_check("after_abort");
    chk("after_abort_crc_const", crc_value, 8'hF3);

    rdy_mode = 2;
    gap_mode = 1'b1;
    for (int f = 0; f < 25; f++) begin
      rm   = 1'($urandom);
      rlen = $urandom_range(1, 8);
      fb.delete();
      for (int i = 0; i < rlen; i++) fb.push_back(8'($urandom));
      if (rm && rlen > 1 && $urandom_range(0, 1) == 1) begin
        rc = 8'hFF;
        for (int i = 0; i < rlen - 1; i++) rc = crc_tab[rc ^ fb[i]];
        fb[rlen - 1] = rc;
      end
      send_frame(rm);
    end
    wait_and_check("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
